// File: rtl/dataslot_read_arbiter.sv
// dataslot_read_arbiter
//   Shares the core's single dataslot-read command channel between NUM_REQ
//   requesters. Round-robin grant, one outstanding command, grant held until
//   the host completion (or timeout), then a one-cycle done pulse back to the
//   owning requester.
// Ports:
//   clk_74a, reset_n           clock / async active-low reset
//   req_valid/req_*            per-requester request and packed fields
//   req_ready                  one-hot combinational accept (IDLE only)
//   req_done/req_status        one-hot completion pulse and its status
//   cmd_valid/cmd_ready/cmd_*  downstream command toward the bridge
//   rsp_valid/rsp_status       host completion strobe
//   busy, grant_id             activity flag and current/last grant index
module dataslot_read_arbiter #(
   parameter int          NUM_REQ        = 4,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd0,
   localparam int         GW             = $clog2(NUM_REQ)
) (
   input  logic                   clk_74a,
   input  logic                   reset_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [NUM_REQ*16-1:0]  req_slot_id,
   input  logic [NUM_REQ*32-1:0]  req_offset,
   input  logic [NUM_REQ*32-1:0]  req_bridge_addr,
   input  logic [NUM_REQ*32-1:0]  req_length,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [NUM_REQ-1:0]     req_done,
   output logic [2:0]             req_status,
   output logic                   cmd_valid,
   input  logic                   cmd_ready,
   output logic [15:0]            cmd_slot_id,
   output logic [31:0]            cmd_offset,
   output logic [31:0]            cmd_bridge_addr,
   output logic [31:0]            cmd_length,
   input  logic                   rsp_valid,
   input  logic [2:0]             rsp_status,
   output logic                   busy,
   output logic [GW-1:0]          grant_id
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t        state;
   logic [GW-1:0] last_grant;
   logic [GW-1:0] sel;
   logic          found;
   int            sel_i;
   logic [31:0]   tcnt;
   logic          timeout_hit;

   // First pending requester searching upward from last_grant+1, wrapping.
   always_comb begin
      sel   = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!found && req_valid[(int'(last_grant) + k) % NUM_REQ]) begin
            found = 1'b1;
            sel   = GW'((int'(last_grant) + k) % NUM_REQ);
         end
      end
   end

   assign sel_i     = int'(sel);
   assign req_ready = (state == IDLE && found) ? (NUM_REQ'(1) << sel) : '0;

   // Counter holds the number of completed WAIT cycles; expiry fires on the
   // TIMEOUT_CYCLES-th WAIT cycle so DONE lands TIMEOUT_CYCLES edges after
   // the command handshake.
   assign timeout_hit = (TIMEOUT_CYCLES != 32'd0) &&
                        (tcnt == TIMEOUT_CYCLES - 32'd1);

   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         last_grant      <= GW'(NUM_REQ - 1);
         grant_id        <= '0;
         cmd_valid       <= 1'b0;
         cmd_slot_id     <= '0;
         cmd_offset      <= '0;
         cmd_bridge_addr <= '0;
         cmd_length      <= '0;
         req_done        <= '0;
         req_status      <= '0;
         busy            <= 1'b0;
         tcnt            <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  grant_id        <= sel;
                  cmd_slot_id     <= req_slot_id[16*sel_i +: 16];
                  cmd_offset      <= req_offset[32*sel_i +: 32];
                  cmd_bridge_addr <= req_bridge_addr[32*sel_i +: 32];
                  cmd_length      <= req_length[32*sel_i +: 32];
                  cmd_valid       <= 1'b1;
                  busy            <= 1'b1;
                  state           <= ISSUE;
               end
            end
            ISSUE: begin
               // rsp_valid is deliberately not looked at here.
               if (cmd_ready) begin
                  cmd_valid <= 1'b0;
                  tcnt      <= '0;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               // A real response beats a simultaneous expiry.
               if (rsp_valid) begin
                  req_status <= rsp_status;
                  req_done   <= NUM_REQ'(1) << grant_id;
                  state      <= DONE;
               end else if (timeout_hit) begin
                  req_status <= 3'b111;
                  req_done   <= NUM_REQ'(1) << grant_id;
                  state      <= DONE;
               end else if (tcnt != 32'hFFFF_FFFF) begin
                  tcnt <= tcnt + 32'd1;
               end
            end
            DONE: begin
               req_done   <= '0;
               last_grant <= grant_id;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dataslot_read_arbiter.sv
// tb_dataslot_read_arbiter
//   Randomized scenarios against a round-robin reference model kept as a
//   plain "last granted index" integer plus spec-level latency expectations.
module tb_dataslot_read_arbiter;

   localparam int N  = 4;
   localparam int TO = 100;

   logic            clk_74a = 1'b0;
   logic            reset_n;
   logic [N-1:0]    req_valid;
   logic [N*16-1:0] req_slot_id;
   logic [N*32-1:0] req_offset, req_bridge_addr, req_length;
   logic [N-1:0]    req_ready, req_done;
   logic [2:0]      req_status;
   logic            cmd_valid, cmd_ready;
   logic [15:0]     cmd_slot_id;
   logic [31:0]     cmd_offset, cmd_bridge_addr, cmd_length;
   logic            rsp_valid;
   logic [2:0]      rsp_status;
   logic            busy;
   logic [1:0]      grant_id;

   int checks = 0;
   int errors = 0;
   int model_last;

   dataslot_read_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
      .clk_74a(clk_74a), .reset_n(reset_n),
      .req_valid(req_valid), .req_slot_id(req_slot_id), .req_offset(req_offset),
      .req_bridge_addr(req_bridge_addr), .req_length(req_length),
      .req_ready(req_ready), .req_done(req_done), .req_status(req_status),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_slot_id(cmd_slot_id),
      .cmd_offset(cmd_offset), .cmd_bridge_addr(cmd_bridge_addr),
      .cmd_length(cmd_length), .rsp_valid(rsp_valid), .rsp_status(rsp_status),
      .busy(busy), .grant_id(grant_id)
   );

   always #5 clk_74a = ~clk_74a;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Reference arbiter: first set bit after the last winner, modulo N.
   function automatic int model_pick(input logic [N-1:0] m);
      for (int k = 1; k <= N; k++)
         if (m[(model_last + k) % N]) return (model_last + k) % N;
      return -1;
   endfunction

   task automatic step();
      @(posedge clk_74a);
      #1;
   endtask

   task automatic rand_fields();
      for (int i = 0; i < N; i++) begin
         req_slot_id[16*i +: 16]     = 16'($urandom);
         req_offset[32*i +: 32]      = $urandom;
         req_bridge_addr[32*i +: 32] = $urandom;
         req_length[32*i +: 32]      = $urandom;
      end
   endtask

   task automatic apply_reset();
      reset_n = 1'b0; req_valid = '0; cmd_ready = 1'b0;
      rsp_valid = 1'b0; rsp_status = '0;
      repeat (2) step();
      reset_n = 1'b1;
      model_last = N - 1;
      step();
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if ({busy, cmd_valid, grant_id, req_done, req_status, req_ready} !== '0 ||
          {cmd_slot_id, cmd_offset, cmd_bridge_addr, cmd_length} !== '0) begin
         errors++;
         $display("FAIL reset_state: busy=%0b cmd_valid=%0b grant=%0d done=%b status=%0d ready=%b slot=%h want all 0",
                  busy, cmd_valid, grant_id, req_done, req_status, req_ready, cmd_slot_id);
      end
   endtask

   task automatic test_single();
      rand_fields();
      req_slot_id[16*2 +: 16]     = 16'h0001;
      req_offset[32*2 +: 32]      = 32'h100;
      req_bridge_addr[32*2 +: 32] = 32'h0001_0000;
      req_length[32*2 +: 32]      = 32'h400;
      req_valid = 4'b0100;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++; $display("FAIL single_ready: got %b want 0100", req_ready);
      end
      step();
      req_valid = '0;
      checks++;
      if (cmd_valid !== 1'b1 || grant_id !== 2'd2 || busy !== 1'b1 ||
          cmd_slot_id !== 16'h0001 || cmd_offset !== 32'h100 ||
          cmd_bridge_addr !== 32'h0001_0000 || cmd_length !== 32'h400) begin
         errors++;
         $display("FAIL single_cmd: v=%0b g=%0d slot=%h off=%h addr=%h len=%h want 1 2 0001 100 00010000 400",
                  cmd_valid, grant_id, cmd_slot_id, cmd_offset, cmd_bridge_addr, cmd_length);
      end
      cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
      repeat (4) step();
      rsp_valid = 1'b1; rsp_status = 3'b000;
      step();
      rsp_valid = 1'b0;
      checks++;
      if (req_done !== 4'b0100 || req_status !== 3'b000) begin
         errors++; $display("FAIL single_done: done=%b st=%0d want 0100 0", req_done, req_status);
      end
      model_last = 2;
      step();
      checks++;
      if (req_done !== '0 || busy !== 1'b0) begin
         errors++; $display("FAIL single_idle: done=%b busy=%0b want 0 0", req_done, busy);
      end
   endtask

   task automatic test_round_robin();
      int exp;
      logic [2:0] st;
      apply_reset();
      req_valid = 4'hF;
      for (int n = 0; n < 5; n++) begin
         rand_fields();
         exp = model_pick(req_valid);
         #1;
         checks++;
         if (req_ready !== 4'(1 << exp) || exp !== n % N) begin
            errors++; $display("FAIL rr_ready[%0d]: got %b want %b", n, req_ready, 4'(1 << (n % N)));
         end
         step();
         checks++;
         if (grant_id !== 2'(exp) || cmd_slot_id !== req_slot_id[16*exp +: 16] ||
             cmd_length !== req_length[32*exp +: 32]) begin
            errors++; $display("FAIL rr_grant[%0d]: got %0d slot=%h want %0d slot=%h",
                               n, grant_id, cmd_slot_id, exp, req_slot_id[16*exp +: 16]);
         end
         cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
         repeat ($urandom_range(0, 3)) step();
         st = 3'($urandom);
         rsp_valid = 1'b1; rsp_status = st;
         step();
         rsp_valid = 1'b0;
         checks++;
         if (req_done !== 4'(1 << exp) || req_status !== st) begin
            errors++; $display("FAIL rr_done[%0d]: done=%b st=%0d want %b %0d",
                               n, req_done, req_status, 4'(1 << exp), st);
         end
         model_last = exp;
         step();
      end
      req_valid = '0;
   endtask

   task automatic test_random();
      int exp;
      logic [2:0] st;
      for (int n = 0; n < 20; n++) begin
         rand_fields();
         req_valid = 4'($urandom_range(1, 15));
         exp = model_pick(req_valid);
         #1;
         checks++;
         if (req_ready !== 4'(1 << exp)) begin
            errors++; $display("FAIL rand_ready[%0d]: mask=%b got %b want %b",
                               n, req_valid, req_ready, 4'(1 << exp));
         end
         step();
         if ($urandom_range(0, 1) == 1) req_valid = '0;
         repeat ($urandom_range(0, 3)) begin
            checks++;
            if (cmd_valid !== 1'b1) begin
               errors++; $display("FAIL rand_hold[%0d]: cmd_valid=%0b want 1", n, cmd_valid);
            end
            step();
         end
         checks++;
         if (cmd_valid !== 1'b1 || grant_id !== 2'(exp) ||
             cmd_offset !== req_offset[32*exp +: 32] ||
             cmd_bridge_addr !== req_bridge_addr[32*exp +: 32]) begin
            errors++; $display("FAIL rand_cmd[%0d]: g=%0d off=%h addr=%h want %0d %h %h", n, grant_id,
                               cmd_offset, cmd_bridge_addr, exp, req_offset[32*exp +: 32],
                               req_bridge_addr[32*exp +: 32]);
         end
         cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
         repeat ($urandom_range(0, 5)) step();
         st = 3'($urandom);
         rsp_valid = 1'b1; rsp_status = st;
         step();
         rsp_valid = 1'b0; req_valid = '0;
         checks++;
         if (req_done !== 4'(1 << exp) || req_status !== st) begin
            errors++; $display("FAIL rand_done[%0d]: done=%b st=%0d want %b %0d",
                               n, req_done, req_status, 4'(1 << exp), st);
         end
         model_last = exp;
         step();
      end
   endtask

   task automatic test_backpressure();
      int exp;
      logic [15:0] s;
      logic [31:0] o, a, l;
      rand_fields();
      req_valid = 4'b0010;
      exp = model_pick(req_valid);
      step();
      req_valid = '0;
      s = req_slot_id[16*exp +: 16]; o = req_offset[32*exp +: 32];
      a = req_bridge_addr[32*exp +: 32]; l = req_length[32*exp +: 32];
      rand_fields();   // ungranted/after-capture field changes must not leak
      for (int c = 0; c < 20; c++) begin
         checks++;
         if (cmd_valid !== 1'b1 || cmd_slot_id !== s || cmd_offset !== o ||
             cmd_bridge_addr !== a || cmd_length !== l || req_done !== '0) begin
            errors++; $display("FAIL bp_stable[%0d]: v=%0b slot=%h off=%h done=%b want 1 %h %h 0",
                               c, cmd_valid, cmd_slot_id, cmd_offset, req_done, s, o);
         end
         rsp_valid = (c % 3 == 0); rsp_status = 3'b001;
         step();
      end
      // response coinciding with the handshake must also be ignored
      rsp_valid = 1'b1; cmd_ready = 1'b1;
      step();
      rsp_valid = 1'b0; cmd_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (cmd_valid !== 1'b0 || busy !== 1'b1 || req_done !== '0) begin
            errors++; $display("FAIL bp_wait[%0d]: v=%0b busy=%0b done=%b want 0 1 0",
                               c, cmd_valid, busy, req_done);
         end
         step();
      end
      rsp_valid = 1'b1; rsp_status = 3'b101;
      step();
      rsp_valid = 1'b0;
      checks++;
      if (req_done !== 4'(1 << exp) || req_status !== 3'b101) begin
         errors++; $display("FAIL bp_done: done=%b st=%0d want %b 5", req_done, req_status, 4'(1 << exp));
      end
      model_last = exp;
      step();
   endtask

   task automatic test_timeout();
      int exp, k;
      bit got;
      logic [2:0] want;
      for (int rep = 0; rep < 2; rep++) begin
         rand_fields();
         req_valid = 4'($urandom_range(1, 15));
         exp = model_pick(req_valid);
         step();
         req_valid = '0;
         cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
         k = 0; got = 1'b0;
         while (k < 2 * TO && !got) begin
            if (rep == 1 && k == TO - 1) begin
               rsp_valid = 1'b1; rsp_status = 3'b010;
            end
            step();
            rsp_valid = 1'b0;
            k++;
            if (req_done !== '0) got = 1'b1;
         end
         want = (rep == 1) ? 3'b010 : 3'b111;
         checks++;
         if (!got || k !== TO || req_done !== 4'(1 << exp) || req_status !== want) begin
            errors++; $display("FAIL timeout[%0d]: got=%0b at %0d done=%b st=%0d want at %0d %b %0d",
                               rep, got, k, req_done, req_status, TO, 4'(1 << exp), want);
         end
         model_last = exp;
         step();
      end
   endtask

   task automatic test_reset_mid();
      rand_fields();
      req_valid = 4'b0010;
      step();
      req_valid = '0;
      cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
      repeat (3) step();
      reset_n = 1'b0;
      #1;
      checks++;
      if ({busy, cmd_valid, grant_id, req_done, req_status, req_ready} !== '0 ||
          {cmd_slot_id, cmd_offset, cmd_bridge_addr, cmd_length} !== '0) begin
         errors++; $display("FAIL reset_mid: busy=%0b v=%0b g=%0d done=%b st=%0d slot=%h want all 0",
                            busy, cmd_valid, grant_id, req_done, req_status, cmd_slot_id);
      end
      rsp_valid = 1'b1;
      step();
      rsp_valid = 1'b0;
      reset_n = 1'b1;
      model_last = N - 1;
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if (req_done !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_mid_quiet[%0d]: done=%b busy=%0b want 0 0", c, req_done, busy);
         end
      end
      req_valid = 4'b1001;
      #1;
      checks++;
      if (req_ready !== 4'(1 << model_pick(req_valid))) begin
         errors++; $display("FAIL reset_mid_prio: got %b want 0001", req_ready);
      end
      req_valid = '0;
   endtask

   task automatic test_spurious();
      apply_reset();
      for (int c = 0; c < 4; c++) begin
         rsp_valid = 1'b1; rsp_status = 3'($urandom);
         step();
         checks++;
         if (req_done !== '0 || busy !== 1'b0 || cmd_valid !== 1'b0) begin
            errors++; $display("FAIL spurious[%0d]: done=%b busy=%0b v=%0b want 0 0 0",
                               c, req_done, busy, cmd_valid);
         end
      end
      rsp_valid = 1'b0;
      req_valid = 4'b1111;
      #1;
      checks++;
      if (req_ready !== 4'(1 << model_pick(req_valid))) begin
         errors++; $display("FAIL spurious_prio: got %b want 0001", req_ready);
      end
      req_valid = '0;
   endtask

   initial begin
      req_valid = '0; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_status = '0;
      req_slot_id = '0; req_offset = '0; req_bridge_addr = '0; req_length = '0;
      reset_n = 1'b1;
      test_reset();
      test_single();
      test_round_robin();
      test_random();
      test_backpressure();
      test_timeout();
      test_reset_mid();
      test_spurious();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
